data_ram_ucode_sequencer: RTL and testbench

Generates the 24-bit read and write uCode words that drive the layered data RAM bank. It collects RX_LEN input samples into the receiver buffer, then runs the seven compute layers in order, CONV1D_1st through FC_2nd. For each layer it walks depth and width counters for reads, and emits the matching write uCode delayed by the processing-element pipeline latency. Done pulses when FC_2nd write-back completes.

---
 rtl/data_ram_ctrl_pkg.sv | 58 +++++
 rtl/ucode_delay_line.sv | 40 ++++
 rtl/data_ram_ucode_sequencer.sv | 140 ++++++++++++++
 tb/tb_data_ram_ucode_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_ctrl_pkg.sv
// Shared types, uCode field layout and per-layer geometry for the data RAM
// uCode sequencer.
package data_ram_ctrl_pkg;

    localparam int unsigned UC_W       = 24;
    localparam int unsigned WIDTH_W    = 9;
    localparam int unsigned DEPTH_W    = 5;
    localparam int unsigned MODE_W     = 9;
    localparam int unsigned LAYER_W    = 3;
    localparam int unsigned NUM_LAYERS = 7;

    localparam int unsigned EN_BIT    = 0;
    localparam int unsigned MODE_LSB  = 1;
    localparam int unsigned DEPTH_LSB = 10;
    localparam int unsigned WIDTH_LSB = 15;

    localparam logic [MODE_W-1:0] MODE_RECEIVER       = 9'h100;
    localparam logic [MODE_W-1:0] MODE_TRANSMITTER    = 9'h080;
    localparam logic [MODE_W-1:0] MODE_CONV1D_1ST     = 9'h040;
    localparam logic [MODE_W-1:0] MODE_MAXPOOL        = 9'h020;
    localparam logic [MODE_W-1:0] MODE_CONV1D_2ND     = 9'h010;
    localparam logic [MODE_W-1:0] MODE_CONV1D_3RD     = 9'h008;
    localparam logic [MODE_W-1:0] MODE_GLOBAL_MAXPOOL = 9'h004;
    localparam logic [MODE_W-1:0] MODE_FC_1ST         = 9'h002;
    localparam logic [MODE_W-1:0] MODE_FC_2ND         = 9'h001;

    localparam int unsigned LAYER_WIDTH [NUM_LAYERS] = '{185, 92, 90, 88, 88, 32, 16};
    localparam int unsigned LAYER_DEPTH [NUM_LAYERS] = '{1, 8, 8, 16, 32, 1, 1};

    typedef struct packed {
        logic [WIDTH_W-1:0] width;
        logic [DEPTH_W-1:0] depth;
        logic [MODE_W-1:0]  mode;
        logic               enable;
    } ucode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

    // Layer i drives mode bit 6-i.
    function automatic logic [MODE_W-1:0] layer_mode(input logic [LAYER_W-1:0] layer);
        return MODE_CONV1D_1ST >> layer;
    endfunction

    function automatic logic [WIDTH_W-1:0] last_width(input logic [LAYER_W-1:0] layer);
        return WIDTH_W'(LAYER_WIDTH[layer] - 1);
    endfunction

    function automatic logic [DEPTH_W-1:0] last_depth(input logic [LAYER_W-1:0] layer);
        return DEPTH_W'(LAYER_DEPTH[layer] - 1);
    endfunction

endpackage

// File: rtl/ucode_delay_line.sv
// Fixed-latency shift register that turns issued read uCodes into the
// matching write uCodes once the PE pipeline has produced the element.
module ucode_delay_line
    import data_ram_ctrl_pkg::*;
#(
    parameter int unsigned PIPE_LAT = 3
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [UC_W-1:0] Ucode_In,
    output logic [UC_W-1:0] Ucode_Out,
    output logic            Any_Valid_c
);

    logic [UC_W-1:0] stage [PIPE_LAT];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < int'(PIPE_LAT); i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= Ucode_In;
            for (int i = 1; i < int'(PIPE_LAT); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign Ucode_Out = stage[PIPE_LAT-1];

    // Any in-flight enable means a write-back is still pending.
    always_comb begin
        Any_Valid_c = 1'b0;
        for (int i = 0; i < int'(PIPE_LAT); i++) begin
            Any_Valid_c = Any_Valid_c | stage[i][EN_BIT];
        end
    end

endmodule

// File: rtl/data_ram_ucode_sequencer.sv
// Sequences receive, seven compute layers and write-back for the layered
// data RAM bank by emitting read and delayed write uCode words.
module data_ram_ucode_sequencer
    import data_ram_ctrl_pkg::*;
#(
    parameter int unsigned PIPE_LAT = 3,
    parameter int unsigned RX_LEN   = 187
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Rx_Valid,
    input  logic               Stall,
    output logic [UC_W-1:0]    Data_Read_uCode,
    output logic [UC_W-1:0]    Data_Write_uCode,
    output logic [LAYER_W-1:0] Layer,
    output logic               Busy,
    output logic               Done
);

    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
    localparam logic [WIDTH_W-1:0] RX_LAST    = WIDTH_W'(RX_LEN - 1);

    seq_state_t         state;
    logic [WIDTH_W-1:0] rx_cnt;
    logic [WIDTH_W-1:0] w_cnt;
    logic [DEPTH_W-1:0] d_cnt;

    logic [UC_W-1:0] rd_next_c;
    logic [UC_W-1:0] wr_fwd_c;
    logic [UC_W-1:0] dl_out;
    logic            dl_any_c;
    ucode_t          dl_uc_c;

    // Read word issued this cycle; also the delay line input so the write
    // trails the read by exactly PIPE_LAT cycles.
    always_comb begin
        rd_next_c = '0;
        if (state == ST_RUN && !Stall) begin
            rd_next_c = {w_cnt, d_cnt, layer_mode(Layer), 1'b1};
        end
    end

    always_comb begin
        dl_uc_c  = ucode_t'(dl_out);
        wr_fwd_c = '0;
        if (dl_uc_c.enable) begin
            wr_fwd_c = {dl_uc_c.width, dl_uc_c.depth, layer_mode(Layer), 1'b1};
        end
    end

    ucode_delay_line #(
        .PIPE_LAT (PIPE_LAT)
    ) u_delay (
        .Clk         (Clk),
        .Reset       (Reset),
        .Ucode_In    (rd_next_c),
        .Ucode_Out   (dl_out),
        .Any_Valid_c (dl_any_c)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state            <= ST_IDLE;
            rx_cnt           <= '0;
            w_cnt            <= '0;
            d_cnt            <= '0;
            Data_Read_uCode  <= '0;
            Data_Write_uCode <= '0;
            Layer            <= '0;
            Busy             <= 1'b0;
            Done             <= 1'b0;
        end else begin
            Data_Read_uCode <= rd_next_c;
            Done            <= 1'b0;
            case (state)
                ST_IDLE: begin
                    Data_Write_uCode <= '0;
                    if (Start) begin
                        state  <= ST_RX;
                        Busy   <= 1'b1;
                        rx_cnt <= '0;
                    end
                end
                ST_RX: begin
                    Data_Write_uCode <= '0;
                    if (Rx_Valid) begin
                        Data_Write_uCode <= {rx_cnt, DEPTH_W'(0), MODE_RECEIVER, 1'b1};
                        rx_cnt           <= rx_cnt + WIDTH_W'(1);
                        if (rx_cnt == RX_LAST) begin
                            state <= ST_RUN;
                            Layer <= '0;
                            w_cnt <= '0;
                            d_cnt <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    Data_Write_uCode <= wr_fwd_c;
                    // Depth outer, width inner.
                    if (!Stall) begin
                        if (w_cnt == last_width(Layer)) begin
                            w_cnt <= '0;
                            if (d_cnt == last_depth(Layer)) begin
                                state <= ST_DRAIN;
                            end else begin
                                d_cnt <= d_cnt + DEPTH_W'(1);
                            end
                        end else begin
                            w_cnt <= w_cnt + WIDTH_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    Data_Write_uCode <= wr_fwd_c;
                    if (!dl_any_c) begin
                        if (Layer == LAST_LAYER) begin
                            state <= ST_DONE;
                            Done  <= 1'b1;
                            Busy  <= 1'b0;
                        end else begin
                            state <= ST_RUN;
                            Layer <= Layer + LAYER_W'(1);
                            w_cnt <= '0;
                            d_cnt <= '0;
                        end
                    end
                end
                ST_DONE: begin
                    Data_Write_uCode <= '0;
                    state            <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_ram_ucode_sequencer.sv
// Directed bench for data_ram_ucode_sequencer: receive phase, full seven-layer
// run with a stall in layer 1, start/valid misuse and mid-run reset.
module tb_data_ram_ucode_sequencer;

    localparam int TOTAL_RD = 5913;
    localparam logic [23:0] STALL_AT  = {9'd91, 5'd2, 9'h020, 1'b1};
    localparam logic [23:0] AFTER_STL = {9'd0, 5'd3, 9'h020, 1'b1};
    localparam logic [23:0] LAST_RD   = {9'd15, 5'd0, 9'h001, 1'b1};

    int          exp_w    [7] = '{185, 92, 90, 88, 88, 32, 16};
    int          exp_d    [7] = '{1, 8, 8, 16, 32, 1, 1};
    logic [8:0]  exp_mode [7] = '{9'h040, 9'h020, 9'h010, 9'h008, 9'h004, 9'h002, 9'h001};

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Rx_Valid = 1'b0;
    logic        Stall = 1'b0;
    logic [23:0] Data_Read_uCode;
    logic [23:0] Data_Write_uCode;
    logic [2:0]  Layer;
    logic        Busy;
    logic        Done;

    data_ram_ucode_sequencer dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .Start            (Start),
        .Rx_Valid         (Rx_Valid),
        .Stall            (Stall),
        .Data_Read_uCode  (Data_Read_uCode),
        .Data_Write_uCode (Data_Write_uCode),
        .Layer            (Layer),
        .Busy             (Busy),
        .Done             (Done)
    );

    initial forever #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    typedef struct {
        int          cyc;
        logic [23:0] v;
        logic [2:0]  layer;
    } rec_t;

    rec_t rd_q[$];
    rec_t wr_q[$];
    int   cyc = 0;
    bit   rec = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    logic busy_after = 1'b1;
    int   layer_chg [8];

    // Cycle monitor sampling on the falling edge.
    initial begin
        rec_t r;
        logic [2:0] prev_layer;
        logic prev_done;
        prev_layer = '0;
        prev_done  = 1'b0;
        for (int i = 0; i < 8; i++) layer_chg[i] = 0;
        forever begin
            @(negedge Clk);
            cyc++;
            if (rec) begin
                r.cyc   = cyc;
                r.layer = Layer;
                if (Data_Read_uCode[0]) begin
                    r.v = Data_Read_uCode;
                    rd_q.push_back(r);
                end
                if (Data_Write_uCode[0]) begin
                    r.v = Data_Write_uCode;
                    wr_q.push_back(r);
                end
                if (Layer != prev_layer) layer_chg[Layer] = cyc;
            end
            prev_layer = Layer;
            if (prev_done) busy_after = Busy;
            if (Done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_done = Done;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stalled;
        bit poked;
        int idx;
        int errs;
        int start_idx [7];
        int l1_writes;

        // Reset state.
        repeat (3) step();
        check("rst_rd", 32'(Data_Read_uCode), 32'h0);
        check("rst_wr", 32'(Data_Write_uCode), 32'h0);
        check("rst_layer", 32'(Layer), 32'h0);
        check("rst_busy", 32'(Busy), 32'h0);
        check("rst_done", 32'(Done), 32'h0);
        Reset = 1'b0;
        step();

        // Rx_Valid while idle is ignored.
        Rx_Valid = 1'b1;
        repeat (3) step();
        Rx_Valid = 1'b0;
        check("idle_rx_wr", 32'(Data_Write_uCode), 32'h0);
        check("idle_rx_busy", 32'(Busy), 32'h0);

        Start = 1'b1;
        step();
        Start = 1'b0;
        check("start_busy", 32'(Busy), 32'h1);

        // Receive phase, one sample every other cycle; a stray Start midway.
        for (int i = 0; i < 187; i++) begin
            Rx_Valid = 1'b1;
            step();
            Rx_Valid = 1'b0;
            check("rx_wr", 32'(Data_Write_uCode), 32'({9'(i), 5'd0, 9'h100, 1'b1}));
            check("rx_rd", 32'(Data_Read_uCode), 32'h0);
            if (i < 186) begin
                if (i == 50) Start = 1'b1;
                step();
                Start = 1'b0;
                check("rx_gap_wr", 32'(Data_Write_uCode), 32'h0);
            end
        end
        step();
        rec = 1;
        check("run_first_rd", 32'(Data_Read_uCode), 32'({9'd0, 5'd0, 9'h040, 1'b1}));

        // Full run: Start/Rx_Valid poke in layer 0, 4-cycle stall in layer 1.
        stalled = 0;
        poked   = 0;
        for (int n = 0; n < 20000 && done_cnt == 0; n++) begin
            step();
            if (!poked && Layer == 3'd0 && Data_Read_uCode[23:15] == 9'd50) begin
                Start    = 1'b1;
                Rx_Valid = 1'b1;
                step();
                Start    = 1'b0;
                Rx_Valid = 1'b0;
                poked    = 1;
            end
            if (!stalled && Layer == 3'd1 && Data_Read_uCode == STALL_AT) begin
                Stall = 1'b1;
                repeat (4) step();
                Stall   = 1'b0;
                stalled = 1;
            end
        end
        check("done_seen", 32'(done_cnt), 32'd1);
        repeat (3) step();
        rec = 0;
        check("busy_after_done", 32'(busy_after), 32'h0);

        check("rd_total", 32'(rd_q.size()), 32'(TOTAL_RD));
        check("wr_total", 32'(wr_q.size()), 32'(TOTAL_RD));
        if (rd_q.size() == TOTAL_RD && wr_q.size() == TOTAL_RD) begin
            idx = 0;
            for (int l = 0; l < 7; l++) begin
                start_idx[l] = idx;
                errs = 0;
                for (int d = 0; d < exp_d[l]; d++) begin
                    for (int w = 0; w < exp_w[l]; w++) begin
                        if (rd_q[idx].v !== {9'(w), 5'(d), exp_mode[l], 1'b1} ||
                            rd_q[idx].layer !== 3'(l)) errs++;
                        idx++;
                    end
                end
                check($sformatf("rd_seq_L%0d", l), 32'(errs), 32'd0);
            end

            errs = 0;
            for (int k = 0; k < TOTAL_RD; k++) begin
                if (wr_q[k].v !== rd_q[k].v || wr_q[k].cyc != rd_q[k].cyc + 3) errs++;
            end
            check("wr_follows_rd", 32'(errs), 32'd0);

            errs = 0;
            for (int k = 0; k < 185; k++) begin
                if (rd_q[k].cyc != rd_q[0].cyc + k) errs++;
            end
            check("l0_back_to_back", 32'(errs), 32'd0);

            l1_writes = 0;
            foreach (wr_q[k]) if (wr_q[k].v[9:1] == 9'h020) l1_writes++;
            check("l1_wr_count", 32'(l1_writes), 32'd736);
            check("stall_rd_at", 32'(rd_q[460].v), 32'(STALL_AT));
            check("stall_rd_next", 32'(rd_q[461].v), 32'(AFTER_STL));
            check("stall_rd_gap", 32'(rd_q[461].cyc - rd_q[460].cyc), 32'd5);
            check("stall_wr_gap", 32'(wr_q[461].cyc - wr_q[460].cyc), 32'd5);

            errs = 0;
            for (int l = 1; l < 7; l++) begin
                if (rd_q[start_idx[l]].cyc <= wr_q[start_idx[l]-1].cyc) errs++;
                if (layer_chg[l] <= wr_q[start_idx[l]-1].cyc) errs++;
                if (layer_chg[l] > rd_q[start_idx[l]].cyc) errs++;
            end
            check("layer_boundaries", 32'(errs), 32'd0);

            check("last_rd", 32'(rd_q[TOTAL_RD-1].v), 32'(LAST_RD));
            check("done_latency", 32'(done_cyc - rd_q[TOTAL_RD-1].cyc), 32'd4);
        end

        // Second run, aborted by reset in layer 3.
        Start = 1'b1;
        step();
        Start = 1'b0;
        Rx_Valid = 1'b1;
        repeat (187) step();
        Rx_Valid = 1'b0;
        for (int n = 0; n < 5000 && Layer != 3'd3; n++) step();
        check("reach_layer3", 32'(Layer), 32'd3);
        repeat (10) step();
        check("pre_rst_rd_en", 32'(Data_Read_uCode[0]), 32'h1);
        #2;
        Reset = 1'b1;
        #1;
        check("mid_rst_rd", 32'(Data_Read_uCode), 32'h0);
        check("mid_rst_wr", 32'(Data_Write_uCode), 32'h0);
        check("mid_rst_busy", 32'(Busy), 32'h0);
        check("mid_rst_layer", 32'(Layer), 32'h0);
        repeat (3) step();
        Reset = 1'b0;
        repeat (30) step();
        check("no_done_after_rst", 32'(done_cnt), 32'd1);
        check("idle_after_rst_rd", 32'(Data_Read_uCode), 32'h0);
        check("idle_after_rst_busy", 32'(Busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
